// File: rtl/spi_slave_multiword.sv
// Oversampled SPI slave: any CPOL/CPHA, either bit order, back-to-back words per chip-select.
// Define SPI_SLAVE_UNDERRUN_EN to add value_miso_avail / underrun (all-ones sent when starved).
module spi_slave_multiword #(
    parameter int WIDTH       = 8,
    parameter int CPOL        = 0,
    parameter int CPHA        = 0,
    parameter int MSB_FIRST   = 1,
    parameter int COUNT_WIDTH = 8
) (
    input  logic                   system_clk,
    input  logic                   system_rst_n,
    input  logic                   pin_ncs,
    input  logic                   pin_clk,
    input  logic                   pin_mosi,
    output logic                   pin_miso,
    output logic                   pin_miso_en,
    input  logic [WIDTH-1:0]       value_miso,
    output logic                   value_miso_load,
    output logic [WIDTH-1:0]       value_mosi,
    output logic                   value_valid,
    output logic                   cs_start,
    output logic                   cs_stop,
    output logic [COUNT_WIDTH-1:0] word_count,
`ifdef SPI_SLAVE_UNDERRUN_EN
    input  logic                   value_miso_avail,
    output logic                   underrun,
`endif
    output logic                   dbg_state_o
);

    typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

    localparam int              BCW      = $clog2(WIDTH);
    localparam logic            CPOL_B   = (CPOL != 0);
    localparam logic            CPHA_B   = (CPHA != 0);
    localparam logic            MSB_B    = (MSB_FIRST != 0);
    localparam logic [BCW-1:0]  LAST_BIT = BCW'(WIDTH - 1);

    // [0],[1] synchronise, [2] holds the previous synced value for edge detection
    logic [2:0] ncs_sync_q, clk_sync_q, mosi_sync_q;
    logic [1:0] vld_q;
    logic       armed_q;

    state_t                 state_q, state_d;
    logic [WIDTH-1:0]       tx_q, tx_d, rx_q, rx_d, value_mosi_q, value_mosi_d;
    logic [BCW-1:0]         bit_cnt_q, bit_cnt_d;
    logic [COUNT_WIDTH-1:0] word_count_q, word_count_d;
    logic                   first_shift_q, first_shift_d;
    logic                   valid_q, valid_d, load_q, load_d;
    logic                   start_q, start_d, stop_q, stop_d;
    logic                   load_word;

    logic             ncs_fall, ncs_rise, clk_rise, clk_fall, lead_edge, trail_edge;
    logic             sample_edge, shift_edge, mosi_s;
    logic [WIDTH-1:0] rx_shift, tx_shift, load_val;

    always_ff @(posedge system_clk or negedge system_rst_n) begin
        if (!system_rst_n) begin
            ncs_sync_q  <= 3'b111;
            clk_sync_q  <= {3{CPOL_B}};
            mosi_sync_q <= 3'b000;
            vld_q       <= 2'b00;
            armed_q     <= 1'b0;
        end else begin
            ncs_sync_q  <= {ncs_sync_q[1:0], pin_ncs};
            clk_sync_q  <= {clk_sync_q[1:0], pin_clk};
            mosi_sync_q <= {mosi_sync_q[1:0], pin_mosi};
            vld_q       <= {vld_q[0], 1'b1};
            // A frame may only start after ncs has genuinely been sampled high since reset
            armed_q     <= armed_q | (vld_q[1] & ncs_sync_q[1]);
        end
    end

    assign ncs_fall    = armed_q & ncs_sync_q[2] & ~ncs_sync_q[1];
    assign ncs_rise    = ~ncs_sync_q[2] & ncs_sync_q[1];
    assign clk_rise    = ~clk_sync_q[2] & clk_sync_q[1];
    assign clk_fall    = clk_sync_q[2] & ~clk_sync_q[1];
    assign lead_edge   = CPOL_B ? clk_fall : clk_rise;
    assign trail_edge  = CPOL_B ? clk_rise : clk_fall;
    assign sample_edge = CPHA_B ? trail_edge : lead_edge;
    assign shift_edge  = CPHA_B ? lead_edge : trail_edge;
    assign mosi_s      = mosi_sync_q[2];

    assign rx_shift = MSB_B ? {rx_q[WIDTH-2:0], mosi_s} : {mosi_s, rx_q[WIDTH-1:1]};
    assign tx_shift = MSB_B ? {tx_q[WIDTH-2:0], 1'b0} : {1'b0, tx_q[WIDTH-1:1]};

`ifdef SPI_SLAVE_UNDERRUN_EN
    assign load_val = value_miso_avail ? value_miso : '1;
`else
    assign load_val = value_miso;
`endif

    always_comb begin
        state_d       = state_q;
        tx_d          = tx_q;
        rx_d          = rx_q;
        bit_cnt_d     = bit_cnt_q;
        word_count_d  = word_count_q;
        value_mosi_d  = value_mosi_q;
        first_shift_d = first_shift_q;
        valid_d       = 1'b0;
        load_d        = 1'b0;
        start_d       = 1'b0;
        stop_d        = 1'b0;
        load_word     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (ncs_fall) begin
                    state_d       = ACTIVE;
                    start_d       = 1'b1;
                    load_word     = 1'b1;
                    bit_cnt_d     = '0;
                    word_count_d  = '0;
                    rx_d          = '0;
                    first_shift_d = CPHA_B;
                end
            end
            ACTIVE: begin
                if (ncs_rise) begin
                    state_d   = IDLE;
                    stop_d    = 1'b1;
                    bit_cnt_d = '0;
                end else if (sample_edge) begin
                    rx_d = rx_shift;
                    if (bit_cnt_q == LAST_BIT) begin
                        bit_cnt_d    = '0;
                        value_mosi_d = rx_shift;
                        valid_d      = 1'b1;
                        if (word_count_q != '1) word_count_d = word_count_q + 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end else if (shift_edge) begin
                    // With CPHA=1 bit 0 is already on the pin, so the first shift edge is a no-op
                    if (first_shift_q) first_shift_d = 1'b0;
                    else if (bit_cnt_q == '0) load_word = 1'b1;
                    else tx_d = tx_shift;
                end
            end
            default: state_d = IDLE;
        endcase
        if (load_word) begin
            load_d = 1'b1;
            tx_d   = load_val;
        end
    end

    always_ff @(posedge system_clk or negedge system_rst_n) begin
        if (!system_rst_n) begin
            state_q       <= IDLE;
            tx_q          <= '0;
            rx_q          <= '0;
            bit_cnt_q     <= '0;
            word_count_q  <= '0;
            value_mosi_q  <= '0;
            first_shift_q <= 1'b0;
            valid_q       <= 1'b0;
            load_q        <= 1'b0;
            start_q       <= 1'b0;
            stop_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            tx_q          <= tx_d;
            rx_q          <= rx_d;
            bit_cnt_q     <= bit_cnt_d;
            word_count_q  <= word_count_d;
            value_mosi_q  <= value_mosi_d;
            first_shift_q <= first_shift_d;
            valid_q       <= valid_d;
            load_q        <= load_d;
            start_q       <= start_d;
            stop_q        <= stop_d;
        end
    end

`ifdef SPI_SLAVE_UNDERRUN_EN
    logic underrun_q, underrun_d;

    always_comb begin
        underrun_d = underrun_q;
        if (start_d) underrun_d = ~value_miso_avail;
        else if (load_d && !value_miso_avail) underrun_d = 1'b1;
    end

    always_ff @(posedge system_clk or negedge system_rst_n) begin
        if (!system_rst_n) underrun_q <= 1'b0;
        else underrun_q <= underrun_d;
    end

    assign underrun = underrun_q;
`endif

    assign pin_miso        = MSB_B ? tx_q[WIDTH-1] : tx_q[0];
    assign pin_miso_en     = (state_q == ACTIVE);
    assign value_miso_load = load_q;
    assign value_mosi      = value_mosi_q;
    assign value_valid     = valid_q;
    assign cs_start        = start_q;
    assign cs_stop         = stop_q;
    assign word_count      = word_count_q;
    assign dbg_state_o     = state_q;

endmodule

// File: tb/tb_spi_slave_multiword.sv
// Directed bench for spi_slave_multiword: four instances (mode 0, mode 3, mode 1, mode 0 LSB-first).
module tb_spi_slave_multiword;

  logic system_clk = 1'b0;
  logic system_rst_n;
  always #5 system_clk = ~system_clk;

  logic [3:0] ncs_p, sclk_p, mosi_p;
  logic [3:0] miso_w, miso_en_w, load_w, valid_w, start_w, stop_w, dbg_w;
  logic [7:0] vmosi_w [4];
  logic [7:0] wc_w [4];
  logic [7:0] vmiso_w [4];
  logic [7:0] tx_list [4][4];
`ifdef SPI_SLAVE_UNDERRUN_EN
  logic [3:0] starve_p;
  logic [3:0] underrun_w;
`endif

  int passed = 0;
  int failed = 0;
  int total = 0;

  // Upstream model: presents tx_list[g][n] as the n-th word of the frame, advancing on each load
  for (genvar g = 0; g < 4; g++) begin : g_dut
    int lif = 0;
    int valid_cnt = 0;
    int load_cnt = 0;
    int start_cnt = 0;
    int stop_cnt = 0;
    logic [7:0] rx_hist [16];
    logic [1:0] sel;

    assign sel = (lif > 3) ? 2'd3 : 2'(lif);
    assign vmiso_w[g] = tx_list[g][sel];

    always @(posedge system_clk) begin
      if (!system_rst_n) lif <= 0;
      else if (start_w[g]) lif <= 1;
      else if (stop_w[g]) lif <= 0;
      else if (load_w[g]) lif <= lif + 1;
      if (valid_w[g]) begin
        rx_hist[valid_cnt[3:0]] <= vmosi_w[g];
        valid_cnt <= valid_cnt + 1;
      end
      if (load_w[g]) load_cnt <= load_cnt + 1;
      if (start_w[g]) start_cnt <= start_cnt + 1;
      if (stop_w[g]) stop_cnt <= stop_cnt + 1;
    end

`ifdef SPI_SLAVE_UNDERRUN_EN
    logic avail;
    assign avail = !(starve_p[g] && lif == 1);
`endif

    spi_slave_multiword #(
      .WIDTH(8),
      .CPOL((g == 1) ? 1 : 0),
      .CPHA((g == 1 || g == 2) ? 1 : 0),
      .MSB_FIRST((g == 3) ? 0 : 1),
      .COUNT_WIDTH(8)
    ) u_dut (
      .system_clk(system_clk),
      .system_rst_n(system_rst_n),
      .pin_ncs(ncs_p[g]),
      .pin_clk(sclk_p[g]),
      .pin_mosi(mosi_p[g]),
      .pin_miso(miso_w[g]),
      .pin_miso_en(miso_en_w[g]),
      .value_miso(vmiso_w[g]),
      .value_miso_load(load_w[g]),
      .value_mosi(vmosi_w[g]),
      .value_valid(valid_w[g]),
      .cs_start(start_w[g]),
      .cs_stop(stop_w[g]),
      .word_count(wc_w[g]),
`ifdef SPI_SLAVE_UNDERRUN_EN
      .value_miso_avail(avail),
      .underrun(underrun_w[g]),
`endif
      .dbg_state_o(dbg_w[g])
    );
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic half();
    repeat (8) @(negedge system_clk);
  endtask

  task automatic cs_low(input int idx);
    ncs_p[idx] = 1'b0;
    half();
  endtask

  task automatic cs_high(input int idx);
    ncs_p[idx] = 1'b1;
    half();
    half();
  endtask

  // Master side of one word; samples MISO on the same edge the slave samples MOSI
  task automatic xfer_word(input int idx, input logic cpol, input logic cpha, input logic msb,
                           input logic [7:0] w, input int nbits, output logic [7:0] r);
    int bi;
    r = 8'h00;
    for (int k = 0; k < nbits; k++) begin
      bi = msb ? 7 - k : k;
      if (!cpha) begin
        mosi_p[idx] = w[bi];
        half();
        r[bi] = miso_w[idx];
        sclk_p[idx] = ~cpol;
        half();
        sclk_p[idx] = cpol;
      end else begin
        sclk_p[idx] = ~cpol;
        mosi_p[idx] = w[bi];
        half();
        r[bi] = miso_w[idx];
        sclk_p[idx] = cpol;
        half();
      end
    end
    half();
  endtask

  initial begin
    logic [7:0] r0, r1, r2;
    int v0, l0, s0, p0;

    ncs_p = 4'hF;
    sclk_p = 4'b0010;
    mosi_p = 4'h0;
`ifdef SPI_SLAVE_UNDERRUN_EN
    starve_p = 4'h0;
`endif
    for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++) tx_list[i][j] = 8'h00;
    tx_list[0][0] = 8'h3C; tx_list[0][1] = 8'h5A; tx_list[0][2] = 8'h5A; tx_list[0][3] = 8'h5A;
    tx_list[1][0] = 8'h3C; tx_list[1][1] = 8'h5A; tx_list[1][2] = 8'h5A; tx_list[1][3] = 8'h5A;
    tx_list[2][0] = 8'h11; tx_list[2][1] = 8'h22; tx_list[2][2] = 8'h33; tx_list[2][3] = 8'h44;
    tx_list[3][0] = 8'h01; tx_list[3][1] = 8'h01; tx_list[3][2] = 8'h01; tx_list[3][3] = 8'h01;

    // Reset values
    system_rst_n = 1'b0;
    repeat (3) @(negedge system_clk);
    check("rst_miso", miso_w[0], 1'b0);
    check("rst_miso_en", miso_en_w[0], 1'b0);
    check("rst_value_mosi", vmosi_w[0], 8'h00);
    check("rst_valid", valid_w[0], 1'b0);
    check("rst_load", load_w[0], 1'b0);
    check("rst_cs_start", start_w[0], 1'b0);
    check("rst_cs_stop", stop_w[0], 1'b0);
    check("rst_word_count", wc_w[0], 8'h00);
    system_rst_n = 1'b1;
    repeat (10) @(negedge system_clk);

    // Mode 0, MSB first: 0xA5 in, 0x3C out
    v0 = g_dut[0].valid_cnt; l0 = g_dut[0].load_cnt; s0 = g_dut[0].start_cnt; p0 = g_dut[0].stop_cnt;
    cs_low(0);
    check("m0_miso_en_active", miso_en_w[0], 1'b1);
    check("m0_dbg_active", dbg_w[0], 1'b1);
    check("m0_first_bit", miso_w[0], 1'b0);
    xfer_word(0, 1'b0, 1'b0, 1'b1, 8'hA5, 8, r0);
    cs_high(0);
    check("m0_master_rx", r0, 8'h3C);
    check("m0_value_mosi", vmosi_w[0], 8'hA5);
    check("m0_valid_pulses", g_dut[0].valid_cnt - v0, 1);
    check("m0_word_count", wc_w[0], 8'd1);
    check("m0_cs_start", g_dut[0].start_cnt - s0, 1);
    check("m0_cs_stop", g_dut[0].stop_cnt - p0, 1);
    check("m0_loads", g_dut[0].load_cnt - l0, 2);
    check("m0_miso_en_idle", miso_en_w[0], 1'b0);

    // Mode 3: same stimulus, clock idles high
    v0 = g_dut[1].valid_cnt; s0 = g_dut[1].start_cnt; p0 = g_dut[1].stop_cnt;
    cs_low(1);
    xfer_word(1, 1'b1, 1'b1, 1'b1, 8'hA5, 8, r0);
    cs_high(1);
    check("m3_master_rx", r0, 8'h3C);
    check("m3_value_mosi", vmosi_w[1], 8'hA5);
    check("m3_valid_pulses", g_dut[1].valid_cnt - v0, 1);
    check("m3_word_count", wc_w[1], 8'd1);
    check("m3_cs_start", g_dut[1].start_cnt - s0, 1);
    check("m3_cs_stop", g_dut[1].stop_cnt - p0, 1);

    // Mode 1, three words in one frame
    v0 = g_dut[2].valid_cnt;
    cs_low(2);
    xfer_word(2, 1'b0, 1'b1, 1'b1, 8'h01, 8, r0);
    xfer_word(2, 1'b0, 1'b1, 1'b1, 8'h02, 8, r1);
    xfer_word(2, 1'b0, 1'b1, 1'b1, 8'h03, 8, r2);
    cs_high(2);
    check("m1_master_rx0", r0, 8'h11);
    check("m1_master_rx1", r1, 8'h22);
    check("m1_master_rx2", r2, 8'h33);
    check("m1_valid_pulses", g_dut[2].valid_cnt - v0, 3);
    check("m1_rx_word0", g_dut[2].rx_hist[v0[3:0]], 8'h01);
    check("m1_rx_word1", g_dut[2].rx_hist[4'(v0 + 1)], 8'h02);
    check("m1_rx_word2", g_dut[2].rx_hist[4'(v0 + 2)], 8'h03);
    check("m1_word_count", wc_w[2], 8'd3);

    // LSB first: 0x80 in, 0x01 out (first bit on the wire is 1)
    cs_low(3);
    check("lsb_first_bit", miso_w[3], 1'b1);
    xfer_word(3, 1'b0, 1'b0, 1'b0, 8'h80, 8, r0);
    cs_high(3);
    check("lsb_value_mosi", vmosi_w[3], 8'h80);
    check("lsb_master_rx", r0, 8'h01);

    // Abort after 5 bits, then a clean frame
    v0 = g_dut[0].valid_cnt; p0 = g_dut[0].stop_cnt;
    cs_low(0);
    xfer_word(0, 1'b0, 1'b0, 1'b1, 8'h5A, 5, r0);
    cs_high(0);
    check("abort_no_valid", g_dut[0].valid_cnt - v0, 0);
    check("abort_cs_stop", g_dut[0].stop_cnt - p0, 1);
    check("abort_value_kept", vmosi_w[0], 8'hA5);
    check("abort_word_count", wc_w[0], 8'd0);
    cs_low(0);
    xfer_word(0, 1'b0, 1'b0, 1'b1, 8'hC3, 8, r0);
    cs_high(0);
    check("after_abort_mosi", vmosi_w[0], 8'hC3);
    check("after_abort_rx", r0, 8'h3C);

    // Reset in the middle of a frame with ncs held low
    cs_low(0);
    xfer_word(0, 1'b0, 1'b0, 1'b1, 8'hF0, 3, r0);
    system_rst_n = 1'b0;
    @(negedge system_clk);
    check("midrst_miso_en", miso_en_w[0], 1'b0);
    check("midrst_value_mosi", vmosi_w[0], 8'h00);
    check("midrst_word_count", wc_w[0], 8'h00);
    check("midrst_miso", miso_w[0], 1'b0);
    system_rst_n = 1'b1;
    s0 = g_dut[0].start_cnt;
    repeat (20) @(negedge system_clk);
    check("midrst_no_start_low", g_dut[0].start_cnt - s0, 0);
    check("midrst_idle", dbg_w[0], 1'b0);
    cs_high(0);
    check("midrst_no_start_high", g_dut[0].start_cnt - s0, 0);
    cs_low(0);
    check("midrst_start_again", g_dut[0].start_cnt - s0, 1);
    xfer_word(0, 1'b0, 1'b0, 1'b1, 8'h96, 8, r0);
    cs_high(0);
    check("midrst_frame_mosi", vmosi_w[0], 8'h96);
    check("midrst_frame_rx", r0, 8'h3C);

`ifdef SPI_SLAVE_UNDERRUN_EN
    // Starved on the second word: all-ones goes out and underrun sticks until the next frame
    starve_p[2] = 1'b1;
    cs_low(2);
    check("ur_clear_at_start", underrun_w[2], 1'b0);
    xfer_word(2, 1'b0, 1'b1, 1'b1, 8'h0A, 8, r0);
    xfer_word(2, 1'b0, 1'b1, 1'b1, 8'h0B, 8, r1);
    cs_high(2);
    check("ur_rx0", r0, 8'h11);
    check("ur_rx1", r1, 8'hFF);
    check("ur_flag", underrun_w[2], 1'b1);
    starve_p[2] = 1'b0;
    cs_low(2);
    check("ur_cleared", underrun_w[2], 1'b0);
    cs_high(2);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
